vx_gpu_ctl_unit: RTL and testbench

Parametrised successor to the core's GPU warp-control execute unit.
- Decodes TMC / WSPAWN / SPLIT / BAR requests from the issue stage into warp-control packets.
- Buffers results in an OUT_DEPTH-entry output queue, so issue continues while commit backpressures.
- Owns the barrier table: counts arrivals per barrier and emits a release mask itself, instead of forwarding raw barrier ops to the warp scheduler.
- Sits between the dispatch stage and the warp scheduler / commit arbiter.

---
 rtl/vx_gpu_ctl_unit_pkg.sv | 29 ++
 rtl/vx_gpu_ctl_unit_bar_table.sv | 80 ++++++++
 rtl/vx_gpu_ctl_unit.sv | 214 +++++++++++++++++++++
 tb/tb_vx_gpu_ctl_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_ctl_unit_pkg.sv
// Shared definitions for the GPU warp-control execute unit:
// op encodings, fixed field widths and the mask-decode helper.
package vx_gpu_ctl_unit_pkg;

    localparam int OP_BITS = 2;
    localparam int PC_BITS = 32;
    localparam int RD_BITS = 5;
    localparam int XLEN    = 32;

    typedef enum logic [OP_BITS-1:0] {
        GPU_TMC    = 2'd0,
        GPU_WSPAWN = 2'd1,
        GPU_SPLIT  = 2'd2,
        GPU_BAR    = 2'd3
    } gpu_op_e;

    // Bit i set when i < n. Counts of 32 or more give all ones, so any
    // narrower slice of the result saturates naturally.
    function automatic logic [XLEN-1:0] thermo32(input logic [XLEN-1:0] n);
        logic [XLEN-1:0] r;
        if (n >= XLEN'(XLEN)) begin
            r = '1;
        end else begin
            r = (XLEN'(1) << n) - XLEN'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/vx_gpu_ctl_unit_bar_table.sv
// Barrier table: per-barrier arrival count and waiting-warp mask.
// An arrival either releases the barrier (count already equals size-1)
// or parks the warp. A warp arriving twice at the same barrier is a
// protocol error; it is flagged and the count is left unchanged.
module vx_gpu_bar_table
    import vx_gpu_ctl_unit_pkg::*;
#(
    parameter  int NUM_WARPS    = 4,
    parameter  int NUM_BARRIERS = 4,
    localparam int WID_W        = $clog2(NUM_WARPS),
    localparam int BAR_W        = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arrive_valid,
    input  logic [BAR_W-1:0]     arrive_id,
    input  logic [WID_W-1:0]     arrive_wid,
    input  logic [WID_W-1:0]     arrive_size_m1,
    output logic                 wait_valid,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_wmask
);

    logic [WID_W-1:0]     cnt_q  [NUM_BARRIERS];
    logic [WID_W-1:0]     cnt_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] mask_d [NUM_BARRIERS];

    logic [BAR_W-1:0]     idx;
    logic [NUM_WARPS-1:0] wid_oh;
    logic [WID_W-1:0]     cur_cnt;
    logic [NUM_WARPS-1:0] cur_mask;
    logic                 dup;

    // Look up the addressed entry and decide wait vs release.
    always_comb begin
        idx           = (NUM_BARRIERS > 1) ? arrive_id : '0;
        wid_oh        = NUM_WARPS'(1) << arrive_wid;
        cur_cnt       = cnt_q[idx];
        cur_mask      = mask_q[idx];
        dup           = |(cur_mask & wid_oh);
        release_valid = arrive_valid && (cur_cnt == arrive_size_m1);
        wait_valid    = arrive_valid && !release_valid;
        release_wmask = release_valid ? (cur_mask | wid_oh) : '0;
    end

    // Next table contents: clear on release, record a new waiter otherwise.
    always_comb begin
        cnt_d  = cnt_q;
        mask_d = mask_q;
        if (release_valid) begin
            cnt_d[idx]  = '0;
            mask_d[idx] = '0;
        end else if (wait_valid && !dup) begin
            cnt_d[idx]  = cur_cnt + WID_W'(1);
            mask_d[idx] = cur_mask | wid_oh;
        end
    end

    // Table registers; reset empties every barrier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                cnt_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    // A warp must not arrive at a barrier it is already waiting on.
    always_ff @(posedge clk) begin
        if (reset_n && wait_valid) begin
            assert (!dup);
        end
    end

endmodule

// File: rtl/vx_gpu_ctl_unit.sv
// GPU warp-control execute unit. Requests are queued raw in a small FIFO
// and decoded from the head into TMC / WSPAWN / SPLIT / BAR packets at
// commit; barrier bookkeeping happens in vx_gpu_bar_table on commit.
// Optional build macro GPU_CTL_PERF_EN adds perf_bar_stalls and
// perf_queue_full event counters.
module vx_gpu_ctl_unit
    import vx_gpu_ctl_unit_pkg::*;
#(
    parameter  int NUM_WARPS    = 4,
    parameter  int NUM_THREADS  = 4,
    parameter  int NUM_BARRIERS = 4,
    parameter  int OUT_DEPTH    = 2,
    localparam int WID_W        = $clog2(NUM_WARPS),
    localparam int BAR_W        = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
`ifdef GPU_CTL_PERF_EN
    output logic [31:0]                 perf_bar_stalls,
    output logic [31:0]                 perf_queue_full,
`endif
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [OP_BITS-1:0]          req_op,
    input  logic [WID_W-1:0]            req_wid,
    input  logic [NUM_THREADS-1:0]      req_tmask,
    input  logic [PC_BITS-1:0]          req_pc,
    input  logic [PC_BITS-1:0]          req_next_pc,
    input  logic [NUM_THREADS*XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0]             req_rs2,
    input  logic [RD_BITS-1:0]          req_rd,
    input  logic                        req_wb,
    output logic                        commit_valid,
    input  logic                        commit_ready,
    output logic [WID_W-1:0]            commit_wid,
    output logic [NUM_THREADS-1:0]      commit_tmask,
    output logic [PC_BITS-1:0]          commit_pc,
    output logic [RD_BITS-1:0]          commit_rd,
    output logic                        commit_wb,
    output logic                        commit_eop,
    output logic                        ctl_valid,
    output logic [WID_W-1:0]            ctl_wid,
    output logic                        tmc_valid,
    output logic [NUM_THREADS-1:0]      tmc_tmask,
    output logic                        wspawn_valid,
    output logic [NUM_WARPS-1:0]        wspawn_wmask,
    output logic [PC_BITS-1:0]          wspawn_pc,
    output logic                        split_valid,
    output logic                        split_diverged,
    output logic [NUM_THREADS-1:0]      split_then,
    output logic [NUM_THREADS-1:0]      split_else,
    output logic [PC_BITS-1:0]          split_pc,
    output logic                        bar_wait_valid,
    output logic                        bar_release_valid,
    output logic [NUM_WARPS-1:0]        bar_release_wmask
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    // Only lane-0 of rs1 is kept whole; the other lanes contribute bit 0.
    typedef struct packed {
        gpu_op_e                op;
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
        logic [PC_BITS-1:0]     next_pc;
        logic [XLEN-1:0]        rs1_0;
        logic [NUM_THREADS-1:0] taken;
        logic [XLEN-1:0]        rs2;
        logic [RD_BITS-1:0]     rd;
        logic                   wb;
    } entry_t;

    entry_t           mem_q [OUT_DEPTH];
    entry_t           push_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, push, pop;

    logic [XLEN-1:0]  thermo;
    logic [XLEN-1:0]  rs2_m1;
    logic [BAR_W-1:0] bar_id;
    logic             unused_rs1;
    logic             unused_bits;

    // Pack the incoming request into a queue entry.
    always_comb begin
        push_entry         = '0;
        push_entry.op      = gpu_op_e'(req_op);
        push_entry.wid     = req_wid;
        push_entry.tmask   = req_tmask;
        push_entry.pc      = req_pc;
        push_entry.next_pc = req_next_pc;
        push_entry.rs1_0   = req_rs1[XLEN-1:0];
        push_entry.rs2     = req_rs2;
        push_entry.rd      = req_rd;
        push_entry.wb      = req_wb;
        for (int i = 0; i < NUM_THREADS; i++) begin
            push_entry.taken[i] = req_rs1[i*XLEN];
        end
    end

    // Queue control. A full queue still accepts when the head leaves this cycle.
    always_comb begin
        full         = (count_q == CNT_W'(OUT_DEPTH));
        commit_valid = (count_q != '0);
        req_ready    = !full || commit_ready;
        pop          = commit_valid && commit_ready;
        push         = req_valid && req_ready;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Queue pointers and occupancy; reset drops anything queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Decode the head entry into commit and warp-control payloads.
    always_comb begin
        head           = mem_q[rd_ptr_q];
        thermo         = thermo32(head.rs1_0);
        rs2_m1         = head.rs2 - XLEN'(1);
        bar_id         = head.rs1_0[BAR_W-1:0];

        commit_wid     = head.wid;
        commit_tmask   = head.tmask;
        commit_pc      = head.pc;
        commit_rd      = head.rd;
        commit_wb      = head.wb;
        commit_eop     = 1'b1;

        ctl_valid      = pop;
        ctl_wid        = head.wid;
        tmc_valid      = pop && (head.op == GPU_TMC);
        tmc_tmask      = thermo[NUM_THREADS-1:0];
        wspawn_valid   = pop && (head.op == GPU_WSPAWN);
        wspawn_wmask   = thermo[NUM_WARPS-1:0];
        wspawn_pc      = head.rs2;
        split_valid    = pop && (head.op == GPU_SPLIT);
        split_then     = head.tmask & head.taken;
        split_else     = head.tmask & ~head.taken;
        split_diverged = (|split_then) && (|split_else);
        split_pc       = head.next_pc;
    end

    assign unused_rs1  = ^req_rs1;
    assign unused_bits = ^{rs2_m1, thermo, head.rs1_0};

    vx_gpu_bar_table #(
        .NUM_WARPS    (NUM_WARPS),
        .NUM_BARRIERS (NUM_BARRIERS)
    ) u_bar_table (
        .clk            (clk),
        .reset_n        (reset_n),
        .arrive_valid   (pop && (head.op == GPU_BAR)),
        .arrive_id      (bar_id),
        .arrive_wid     (head.wid),
        .arrive_size_m1 (rs2_m1[WID_W-1:0]),
        .wait_valid     (bar_wait_valid),
        .release_valid  (bar_release_valid),
        .release_wmask  (bar_release_wmask)
    );

`ifdef GPU_CTL_PERF_EN
    logic [31:0] perf_bar_stalls_q, perf_bar_stalls_d;
    logic [31:0] perf_queue_full_q, perf_queue_full_d;

    // Event counters wrap naturally at 2^32.
    always_comb begin
        perf_bar_stalls_d = perf_bar_stalls_q + 32'(bar_wait_valid);
        perf_queue_full_d = perf_queue_full_q + 32'(req_valid && !req_ready);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_bar_stalls_q <= '0;
            perf_queue_full_q <= '0;
        end else begin
            perf_bar_stalls_q <= perf_bar_stalls_d;
            perf_queue_full_q <= perf_queue_full_d;
        end
    end

    assign perf_bar_stalls = perf_bar_stalls_q;
    assign perf_queue_full = perf_queue_full_q;
`endif

endmodule

// File: tb/tb_vx_gpu_ctl_unit.sv
// Self-checking bench for vx_gpu_ctl_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_vx_gpu_ctl_unit;

    localparam int NW    = 4;
    localparam int NT    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 2;
    localparam int WW    = $clog2(NW);

    localparam int OP_TMC = 0, OP_WSPAWN = 1, OP_SPLIT = 2, OP_BAR = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = '0;
    logic [WW-1:0]     req_wid = '0;
    logic [NT-1:0]     req_tmask = '0;
    logic [31:0]       req_pc = '0;
    logic [31:0]       req_next_pc = '0;
    logic [NT*32-1:0]  req_rs1 = '0;
    logic [31:0]       req_rs2 = '0;
    logic [4:0]        req_rd = '0;
    logic              req_wb = 1'b0;
    logic              commit_valid;
    logic              commit_ready = 1'b0;
    logic [WW-1:0]     commit_wid;
    logic [NT-1:0]     commit_tmask;
    logic [31:0]       commit_pc;
    logic [4:0]        commit_rd;
    logic              commit_wb;
    logic              commit_eop;
    logic              ctl_valid;
    logic [WW-1:0]     ctl_wid;
    logic              tmc_valid;
    logic [NT-1:0]     tmc_tmask;
    logic              wspawn_valid;
    logic [NW-1:0]     wspawn_wmask;
    logic [31:0]       wspawn_pc;
    logic              split_valid;
    logic              split_diverged;
    logic [NT-1:0]     split_then;
    logic [NT-1:0]     split_else;
    logic [31:0]       split_pc;
    logic              bar_wait_valid;
    logic              bar_release_valid;
    logic [NW-1:0]     bar_release_wmask;
`ifdef GPU_CTL_PERF_EN
    logic [31:0]       perf_bar_stalls;
    logic [31:0]       perf_queue_full;
`endif

    always #5 clk = ~clk;

    vx_gpu_ctl_unit #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_BARRIERS(NB), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
`ifdef GPU_CTL_PERF_EN
        .perf_bar_stalls(perf_bar_stalls), .perf_queue_full(perf_queue_full),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_wid(req_wid), .req_tmask(req_tmask), .req_pc(req_pc),
        .req_next_pc(req_next_pc), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rd(req_rd), .req_wb(req_wb),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_wid(commit_wid), .commit_tmask(commit_tmask), .commit_pc(commit_pc),
        .commit_rd(commit_rd), .commit_wb(commit_wb), .commit_eop(commit_eop),
        .ctl_valid(ctl_valid), .ctl_wid(ctl_wid),
        .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
        .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
        .split_valid(split_valid), .split_diverged(split_diverged),
        .split_then(split_then), .split_else(split_else), .split_pc(split_pc),
        .bar_wait_valid(bar_wait_valid), .bar_release_valid(bar_release_valid),
        .bar_release_wmask(bar_release_wmask)
    );

    typedef struct {
        int               op;
        int               wid;
        logic [NT-1:0]    tmask;
        logic [31:0]      pc;
        logic [31:0]      npc;
        logic [NT*32-1:0] rs1;
        logic [31:0]      rs2;
        logic [4:0]       rd;
        logic             wb;
    } pkt_t;

    pkt_t        mq[$];          // packets waiting for commit, oldest first
    int          bq[NB][$];      // warps currently parked at each barrier
    logic [31:0] pf_qfull = '0;
    logic [31:0] pf_stall = '0;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input logic [NT*32-1:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    // Lane 0 carries the full scalar; other lanes carry the taken bit in bit 0.
    function automatic logic [NT*32-1:0] mk_rs1(input logic [31:0] l0, input logic [NT-1:0] tk);
        logic [NT*32-1:0] v;
        v[31:0] = l0;
        for (int i = 1; i < NT; i++) begin
            v[i*32 +: 32] = {31'($urandom), tk[i]};
        end
        return v;
    endfunction

    task automatic cyc(input bit v, input int op, input int wid, input logic [NT-1:0] tm,
                       input logic [NT*32-1:0] rs1, input logic [31:0] rs2, input bit cr);
        pkt_t          p, h;
        bit            has_h, rr, ctl, e_wait, e_rel_v, tk;
        logic [NT-1:0] e_tm, e_then, e_else;
        logic [NW-1:0] e_wm, e_rel;
        int            id, sm1;
        p.op = op; p.wid = wid; p.tmask = tm; p.pc = $urandom; p.npc = p.pc + 32'd4;
        p.rs1 = rs1; p.rs2 = rs2; p.rd = 5'($urandom_range(0, 31)); p.wb = 1'($urandom_range(0, 1));
        req_valid = v; req_op = 2'(op); req_wid = WW'(wid); req_tmask = tm;
        req_pc = p.pc; req_next_pc = p.npc; req_rs1 = rs1; req_rs2 = rs2;
        req_rd = p.rd; req_wb = p.wb; commit_ready = cr;
        #1;
        has_h = (mq.size() != 0);
        h = has_h ? mq[0] : p;
        rr  = (mq.size() < DEPTH) || cr;
        ctl = has_h && cr;
        e_wait = 0; e_rel_v = 0; e_rel = '0; id = 0;
        if (ctl && h.op == OP_BAR) begin
            id  = int'(lane(h.rs1, 0) % NB);
            sm1 = int'((h.rs2 - 32'd1) % 32'(NW));
            if (bq[id].size() == sm1) begin
                e_rel_v = 1;
                e_rel[h.wid] = 1'b1;
                foreach (bq[id][k]) e_rel[bq[id][k]] = 1'b1;
            end else begin
                e_wait = 1;
            end
        end
        chk("req_ready", req_ready, rr);
        chk("commit_valid", commit_valid, has_h);
        chk("ctl_valid", ctl_valid, ctl);
        chk("tmc_valid", tmc_valid, ctl && h.op == OP_TMC);
        chk("wspawn_valid", wspawn_valid, ctl && h.op == OP_WSPAWN);
        chk("split_valid", split_valid, ctl && h.op == OP_SPLIT);
        chk("bar_wait_valid", bar_wait_valid, e_wait);
        chk("bar_release_valid", bar_release_valid, e_rel_v);
`ifdef GPU_CTL_PERF_EN
        chk("perf_queue_full", perf_queue_full, pf_qfull);
        chk("perf_bar_stalls", perf_bar_stalls, pf_stall);
`endif
        if (e_rel_v) chk("bar_release_wmask", bar_release_wmask, e_rel);
        if (has_h) begin
            chk("commit_wid", commit_wid, h.wid);
            chk("commit_tmask", commit_tmask, h.tmask);
            chk("commit_pc", commit_pc, h.pc);
            chk("commit_rd", commit_rd, h.rd);
            chk("commit_wb", commit_wb, h.wb);
            chk("commit_eop", commit_eop, 1);
            chk("ctl_wid", ctl_wid, h.wid);
        end
        if (ctl && h.op == OP_TMC) begin
            for (int i = 0; i < NT; i++) e_tm[i] = (32'(i) < lane(h.rs1, 0));
            chk("tmc_tmask", tmc_tmask, e_tm);
        end
        if (ctl && h.op == OP_WSPAWN) begin
            for (int i = 0; i < NW; i++) e_wm[i] = (32'(i) < lane(h.rs1, 0));
            chk("wspawn_wmask", wspawn_wmask, e_wm);
            chk("wspawn_pc", wspawn_pc, h.rs2);
        end
        if (ctl && h.op == OP_SPLIT) begin
            for (int i = 0; i < NT; i++) begin
                tk = h.rs1[i*32];
                e_then[i] = h.tmask[i] && tk;
                e_else[i] = h.tmask[i] && !tk;
            end
            chk("split_then", split_then, e_then);
            chk("split_else", split_else, e_else);
            chk("split_diverged", split_diverged, (e_then != 0) && (e_else != 0));
            chk("split_pc", split_pc, h.npc);
        end
        pf_qfull += 32'(v && !rr);
        pf_stall += 32'(e_wait);
        if (ctl) begin
            if (h.op == OP_BAR) begin
                if (e_rel_v) bq[id].delete();
                else bq[id].push_back(h.wid);
            end
            void'(mq.pop_front());
        end
        if (v && rr) mq.push_back(p);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        req_valid = 1'b0;
        commit_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_ctl_valid", ctl_valid, 0);
        chk("rst_tmc_valid", tmc_valid, 0);
        chk("rst_wspawn_valid", wspawn_valid, 0);
        chk("rst_split_valid", split_valid, 0);
        chk("rst_bar_wait_valid", bar_wait_valid, 0);
        chk("rst_bar_release_valid", bar_release_valid, 0);
        chk("rst_req_ready", req_ready, 1);
`ifdef GPU_CTL_PERF_EN
        chk("rst_perf_queue_full", perf_queue_full, 0);
        chk("rst_perf_bar_stalls", perf_bar_stalls, 0);
`endif
        mq.delete();
        for (int i = 0; i < NB; i++) bq[i].delete();
        pf_qfull = '0;
        pf_stall = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic bit bar_conflict(input int id, input int wid);
        foreach (bq[id][k]) if (bq[id][k] == wid) return 1;
        foreach (mq[k]) begin
            if (mq[k].op == OP_BAR && mq[k].wid == wid && int'(lane(mq[k].rs1, 0) % NB) == id)
                return 1;
        end
        return 0;
    endfunction

    initial begin
        int op, wid, id;
        logic [31:0] l0, rs2;
        do_reset();

        // TMC mask decode: partial, saturated, halt
        cyc(1, OP_TMC, 1, 4'hF, mk_rs1(32'd2, '0), 32'd0, 1);
        cyc(1, OP_TMC, 2, 4'hF, mk_rs1(32'd9, '0), 32'd0, 1);
        cyc(1, OP_TMC, 3, 4'hF, mk_rs1(32'd0, '0), 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // WSPAWN
        cyc(1, OP_WSPAWN, 0, 4'hF, mk_rs1(32'd3, '0), 32'h0000_0800, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // SPLIT: lanes 1,0,1,0 taken, then all taken
        cyc(1, OP_SPLIT, 1, 4'hF, mk_rs1(32'd1, 4'b0101), 32'd0, 1);
        cyc(1, OP_SPLIT, 2, 4'hF, mk_rs1(32'd1, 4'b1111), 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // BAR id 1, size 3: warps 0, 2 wait, warp 3 releases; warp 1 restarts
        cyc(1, OP_BAR, 0, 4'hF, mk_rs1(32'd1, '0), 32'd3, 1);
        cyc(1, OP_BAR, 2, 4'hF, mk_rs1(32'd1, '0), 32'd3, 1);
        cyc(1, OP_BAR, 3, 4'hF, mk_rs1(32'd1, '0), 32'd3, 1);
        cyc(1, OP_BAR, 1, 4'hF, mk_rs1(32'd1, '0), 32'd3, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // Size 1 releases immediately
        cyc(1, OP_BAR, 2, 4'hF, mk_rs1(32'd3, '0), 32'd1, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // Backpressure: fill, stall three cycles, then pop+push together
        cyc(1, OP_TMC, 0, 4'h1, mk_rs1(32'd1, '0), 32'd0, 0);
        cyc(1, OP_TMC, 1, 4'h3, mk_rs1(32'd2, '0), 32'd0, 0);
        for (int i = 0; i < 3; i++) cyc(1, OP_TMC, 2, 4'h7, mk_rs1(32'd3, '0), 32'd0, 0);
        cyc(1, OP_TMC, 2, 4'h7, mk_rs1(32'd3, '0), 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // Reset with barrier 2 half-full and the queue full
        cyc(1, OP_BAR, 0, 4'hF, mk_rs1(32'd2, '0), 32'd3, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);
        cyc(1, OP_TMC, 1, 4'hF, mk_rs1(32'd1, '0), 32'd0, 0);
        cyc(1, OP_TMC, 2, 4'hF, mk_rs1(32'd1, '0), 32'd0, 0);
        do_reset();
        cyc(1, OP_BAR, 1, 4'hF, mk_rs1(32'd2, '0), 32'd2, 1);
        cyc(1, OP_BAR, 3, 4'hF, mk_rs1(32'd2, '0), 32'd2, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);
        cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            op  = $urandom_range(0, 3);
            wid = $urandom_range(0, NW - 1);
            l0  = 32'($urandom_range(0, 9));
            rs2 = (op == OP_BAR) ? 32'($urandom_range(0, 5)) : $urandom;
            id  = int'(l0 % NB);
            if (op == OP_BAR && bar_conflict(id, wid)) op = OP_TMC;
            cyc(1'($urandom_range(0, 1)), op, wid, 4'($urandom), mk_rs1(l0, 4'($urandom)),
                rs2, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, OP_TMC, 0, 4'h0, '0, 32'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
